// File: rtl/adder_pkg.sv
// Constants shared between the 4-bit adder stage and its result collector.
package adder_pkg;
    localparam int unsigned RESULT_W      = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned STAT_W        = 8;
endpackage

// File: rtl/result_collector_ptr.sv
// Circular buffer pointer: advances by one on inc and wraps modulo DEPTH.
module result_collector_ptr #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/result_collector.sv
// First-word-fall-through buffer for adder results with a sticky overflow flag.
// Define RESULT_COLLECTOR_STATS_EN to add the drop_count/push_count statistics outputs.
module result_collector
    import adder_pkg::*;
#(
    parameter int unsigned DEPTH    = adder_pkg::DEFAULT_DEPTH,
    parameter int unsigned RESULT_W = adder_pkg::RESULT_W,
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                done_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                overflow
`ifdef RESULT_COLLECTOR_STATS_EN
    ,
    output logic [STAT_W-1:0]   drop_count,
    output logic [STAT_W-1:0]   push_count
`endif
);

    logic [RESULT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                overflow_q;
    logic                push;
    logic                pop;
    logic                drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop frees the slot in the same cycle, so a full buffer can still accept.
    assign push      = done_in & (~full | pop);
    assign drop      = done_in & full & ~pop;

    result_collector_ptr #(
        .DEPTH(DEPTH)
    ) u_wr_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (push),
        .ptr  (wr_ptr)
    );

    result_collector_ptr #(
        .DEPTH(DEPTH)
    ) u_rd_ptr (
        .clk  (clk),
        .reset(reset),
        .inc  (pop),
        .ptr  (rd_ptr)
    );

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= result_in;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_data = mem_q[rd_ptr];
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef RESULT_COLLECTOR_STATS_EN
    logic [STAT_W-1:0] drop_cnt_q;
    logic [STAT_W-1:0] push_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            push_cnt_q <= '0;
        end else begin
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + STAT_W'(1);
            end
            if (push) begin
                push_cnt_q <= push_cnt_q + STAT_W'(1);
            end
        end
    end

    assign drop_count = drop_cnt_q;
    assign push_count = push_cnt_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: queue-based reference model plus directed cases.
module tb_result_collector;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       done_in = 1'b0;
    logic [3:0] result_in = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       overflow;
`ifdef RESULT_COLLECTOR_STATS_EN
    logic [7:0] drop_count;
    logic [7:0] push_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    result_collector #(
        .DEPTH   (DEPTH),
        .RESULT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .done_in  (done_in),
        .result_in(result_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .overflow (overflow)
`ifdef RESULT_COLLECTOR_STATS_EN
        ,
        .drop_count(drop_count),
        .push_count(push_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of results.
    logic [3:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_drops = 0;
    int         m_pushes = 0;

    always @(negedge reset) begin
        m_q.delete();
        m_ovf    = 1'b0;
        m_drops  = 0;
        m_pushes = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            bit do_pop;
            bit do_push;
            do_pop  = (m_q.size() != 0) && out_ready;
            do_push = done_in && ((m_q.size() < DEPTH) || do_pop);
            if (done_in && !do_push) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(result_in);
                m_pushes = (m_pushes + 1) % 256;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("m_valid", int'(out_valid), int'(m_q.size() != 0));
        chk("m_count", int'(count), m_q.size());
        chk("m_full", int'(full), int'(m_q.size() == DEPTH));
        chk("m_overflow", int'(overflow), int'(m_ovf));
        if (m_q.size() != 0) chk("m_data", int'(out_data), int'(m_q[0]));
`ifdef RESULT_COLLECTOR_STATS_EN
        chk("m_drop_count", int'(drop_count), m_drops);
        chk("m_push_count", int'(push_count), m_pushes);
`endif
    end

    // Apply inputs across one rising edge; return shortly after the next falling edge.
    task automatic tick(input bit d, input logic [3:0] r, input bit rdy);
        done_in   = d;
        result_in = r;
        out_ready = rdy;
        @(negedge clk);
        #1;
        done_in   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_full", int'(full), 0);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] vals[10];

        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_overflow", int'(overflow), 0);
        reset = 1'b1;

        // First edge after release accepts a push; head visible one cycle later.
        tick(1'b1, 4'h7, 1'b0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 7);
        chk("single_count", int'(count), 1);
        tick(1'b0, 4'h0, 1'b1);
        chk("single_drained", int'(out_valid), 0);

        // Fill, overflow attempt, hold, then drain in order.
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b1, 4'h5, 1'b0);
        tick(1'b1, 4'h9, 1'b0);
        tick(1'b1, 4'hC, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 4);
        tick(1'b1, 4'hF, 1'b0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
`ifdef RESULT_COLLECTOR_STATS_EN
        chk("ovf_drop_count", int'(drop_count), 1);
`endif
        tick(1'b0, 4'h0, 1'b0);
        chk("hold_data", int'(out_data), 3);
        tick(1'b0, 4'h0, 1'b1);
        chk("drain_1", int'(out_data), 5);
        tick(1'b0, 4'h0, 1'b1);
        chk("drain_2", int'(out_data), 9);
        tick(1'b0, 4'h0, 1'b1);
        chk("drain_3", int'(out_data), 12);
        tick(1'b0, 4'h0, 1'b1);
        chk("drain_empty", int'(out_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        pulse_reset();

        // Push and pop together while full.
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b1, 4'h5, 1'b0);
        tick(1'b1, 4'h9, 1'b0);
        tick(1'b1, 4'hC, 1'b0);
        tick(1'b1, 4'hA, 1'b1);
        chk("pp_count", int'(count), 4);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_head", int'(out_data), 5);
        tick(1'b0, 4'h0, 1'b1);
        tick(1'b0, 4'h0, 1'b1);
        chk("pp_third", int'(out_data), 12);
        tick(1'b0, 4'h0, 1'b1);
        chk("pp_fourth", int'(out_data), 10);
        tick(1'b0, 4'h0, 1'b1);
        chk("pp_empty", int'(out_valid), 0);

        // Ten push/pop pairs walk the pointers around the ring.
        for (int i = 0; i < 10; i++) vals[i] = 4'($urandom_range(0, 15));
        tick(1'b1, vals[0], 1'b0);
        for (int i = 1; i < 10; i++) begin
            tick(1'b1, vals[i], 1'b1);
            chk("wrap_data", int'(out_data), int'(vals[i]));
            chk("wrap_count", int'(count), 1);
        end
        tick(1'b0, 4'h0, 1'b1);
        chk("wrap_empty", int'(count), 0);

        // Reset mid-stream discards buffered entries.
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h2, 1'b0);
        pulse_reset();
        tick(1'b1, 4'h6, 1'b0);
        chk("post_rst_data", int'(out_data), 6);
        chk("post_rst_count", int'(count), 1);
        tick(1'b0, 4'h0, 1'b1);
        chk("post_rst_empty", int'(out_valid), 0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) pulse_reset();
            tick(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 9) < 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
